result_checker: RTL and testbench

RESULT_CHECKER -- requirements
Module: result_checker

---
 rtl/result_checker.sv | 167 ++++++++++++++++
 tb/tb_result_checker.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/result_checker.sv
// Result checker: aligns to the golden sequence, then compares golden and DUT samples.
// Optional macro RESULT_CHECKER_SEQ_CHECK_EN adds a golden-sequence continuity check.
module result_checker #(
    parameter int DATA_WIDTH    = 8,
    parameter int MAX_VALUE     = 4,
    parameter int ERR_THRESHOLD = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_Enable,
    input  logic                  i_Clear,
    input  logic [DATA_WIDTH-1:0] i_Golden_Data,
    input  logic [DATA_WIDTH-1:0] i_Dut_Data,
    output logic                  o_Mismatch,
    output logic [15:0]           o_Mismatch_Count,
    output logic                  o_Locked,
    output logic                  o_Fail,
    output logic                  o_Seq_Error,
    output logic [1:0]            o_State
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SYNC  = 2'd1,
        CHECK = 2'd2,
        FAIL  = 2'd3
    } state_t;

    generate
        if (ERR_THRESHOLD < 1 || ERR_THRESHOLD > 15)
            $error("ERR_THRESHOLD must be in 1..15");
        if (MAX_VALUE < 0 || MAX_VALUE >= (1 << DATA_WIDTH))
            $error("MAX_VALUE must fit in DATA_WIDTH");
    endgenerate

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [3:0]            consec_q, consec_d;
    logic                  mm_q, mm_d;
    logic                  fail_q, fail_d;

    logic [DATA_WIDTH-1:0] gold_q, dut_q, prev_gold_q;
    logic                  smp_vld_q, prev_vld_q;
    logic                  golden_step;

    // Sample pipeline: prev_vld_q marks prev_gold_q as a real sample of this enable run.
    always_ff @(posedge clk) begin
        if (rst) begin
            gold_q      <= '0;
            dut_q       <= '0;
            prev_gold_q <= '0;
            smp_vld_q   <= 1'b0;
            prev_vld_q  <= 1'b0;
        end else if (i_Enable) begin
            gold_q      <= i_Golden_Data;
            dut_q       <= i_Dut_Data;
            prev_gold_q <= gold_q;
            smp_vld_q   <= 1'b1;
            prev_vld_q  <= smp_vld_q;
        end else begin
            smp_vld_q   <= 1'b0;
            prev_vld_q  <= 1'b0;
        end
    end

    assign golden_step = smp_vld_q && prev_vld_q && (gold_q != prev_gold_q);

`ifdef RESULT_CHECKER_SEQ_CHECK_EN
    logic seq_q, seq_d;
    logic seq_ok;
    assign seq_ok = (gold_q == DATA_WIDTH'(prev_gold_q + 1'b1)) ||
                    ((prev_gold_q == DATA_WIDTH'(MAX_VALUE)) && (gold_q == '0));
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        consec_d = consec_q;
        mm_d     = 1'b0;
        fail_d   = fail_q;
`ifdef RESULT_CHECKER_SEQ_CHECK_EN
        seq_d    = seq_q;
`endif
        if (i_Clear) begin
            state_d  = IDLE;
            cnt_d    = '0;
            consec_d = '0;
            fail_d   = 1'b0;
`ifdef RESULT_CHECKER_SEQ_CHECK_EN
            seq_d    = 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_Enable) state_d = SYNC;
                end
                SYNC: begin
                    if (!i_Enable) begin
                        state_d  = IDLE;
                        consec_d = '0;
                    end else if (golden_step) begin
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (!i_Enable) begin
                        state_d  = IDLE;
                        consec_d = '0;
                    end else if (smp_vld_q) begin
                        if (gold_q != dut_q) begin
                            mm_d     = 1'b1;
                            cnt_d    = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
                            consec_d = consec_q + 4'd1;
                            if (consec_d == 4'(ERR_THRESHOLD)) begin
                                state_d = FAIL;
                                fail_d  = 1'b1;
                            end
                        end else begin
                            consec_d = '0;
                        end
`ifdef RESULT_CHECKER_SEQ_CHECK_EN
                        if (golden_step && !seq_ok) begin
                            seq_d   = 1'b1;
                            fail_d  = 1'b1;
                            state_d = FAIL;
                        end
`endif
                    end
                end
                default: ; // FAIL holds until clear or reset
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            consec_q <= '0;
            mm_q     <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            consec_q <= consec_d;
            mm_q     <= mm_d;
            fail_q   <= fail_d;
        end
    end

`ifdef RESULT_CHECKER_SEQ_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) seq_q <= 1'b0;
        else     seq_q <= seq_d;
    end
    assign o_Seq_Error = seq_q;
`else
    assign o_Seq_Error = 1'b0;
`endif

    assign o_Mismatch       = mm_q;
    assign o_Mismatch_Count = cnt_q;
    assign o_Fail           = fail_q;
    assign o_State          = state_q;
    assign o_Locked         = (state_q == CHECK);

endmodule

// File: tb/tb_result_checker.sv
// Directed bench for result_checker: vector table plus multi-cycle corner sequences.
module tb_result_checker;

  logic        clk = 1'b0;
  logic        rst, en, clr;
  logic [7:0]  g, d;
  logic        mm, locked, fail, seq;
  logic [15:0] cnt;
  logic [1:0]  st;

  logic        s_rst, s_en, s_clr;
  logic [7:0]  s_g, s_d;
  logic        s_mm, s_locked, s_fail, s_seq;
  logic [15:0] s_cnt;
  logic [1:0]  s_st;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_checker u_dut (
    .clk(clk), .rst(rst), .i_Enable(en), .i_Clear(clr),
    .i_Golden_Data(g), .i_Dut_Data(d),
    .o_Mismatch(mm), .o_Mismatch_Count(cnt), .o_Locked(locked),
    .o_Fail(fail), .o_Seq_Error(seq), .o_State(st)
  );

  result_checker #(.ERR_THRESHOLD(15)) u_sat (
    .clk(clk), .rst(s_rst), .i_Enable(s_en), .i_Clear(s_clr),
    .i_Golden_Data(s_g), .i_Dut_Data(s_d),
    .o_Mismatch(s_mm), .o_Mismatch_Count(s_cnt), .o_Locked(s_locked),
    .o_Fail(s_fail), .o_Seq_Error(s_seq), .o_State(s_st)
  );

  typedef struct {
    logic        en;
    logic        clr;
    logic [7:0]  g;
    logic [7:0]  d;
    logic [1:0]  st;
    logic        mm;
    logic [15:0] cnt;
    logic        fail;
  } vec_t;

  vec_t vecs[23];

  function automatic vec_t mk(input logic e, input logic c, input logic [7:0] gg,
                              input logic [7:0] dd, input logic [1:0] s, input logic m,
                              input logic [15:0] n, input logic f);
    vec_t v;
    v.en = e; v.clr = c; v.g = gg; v.d = dd; v.st = s; v.mm = m; v.cnt = n; v.fail = f;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic e, input logic c, input logic [7:0] gg, input logic [7:0] dd);
    @(negedge clk);
    en = e; clr = c; g = gg; d = dd;
    @(posedge clk);
    #1;
  endtask

  task automatic lock_in(input string tag);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    step(1, 0, 1, 1);
    chk({tag, " lock state"}, 16'(st), 16'd2);
    chk({tag, " locked"}, 16'(locked), 16'd1);
  endtask

  logic exp_seq_err;

  initial begin
`ifdef RESULT_CHECKER_SEQ_CHECK_EN
    exp_seq_err = 1'b1;
`else
    exp_seq_err = 1'b0;
`endif
    //           en clr  g  d  st mm cnt fail
    vecs[0]  = mk(1, 0, 0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 1, 0, 0, 0);
    vecs[3]  = mk(1, 0, 1, 1, 1, 0, 0, 0);
    vecs[4]  = mk(1, 0, 1, 1, 2, 0, 0, 0);
    vecs[5]  = mk(1, 0, 2, 2, 2, 0, 0, 0);
    vecs[6]  = mk(1, 0, 2, 7, 2, 0, 0, 0);
    vecs[7]  = mk(1, 0, 3, 3, 2, 1, 1, 0);
    vecs[8]  = mk(1, 0, 4, 4, 2, 0, 1, 0);
    vecs[9]  = mk(1, 0, 0, 0, 2, 0, 1, 0);
    vecs[10] = mk(1, 0, 1, 1, 2, 0, 1, 0);
    vecs[11] = mk(1, 0, 2, 9, 2, 0, 1, 0);
    vecs[12] = mk(1, 0, 3, 9, 2, 1, 2, 0);
    vecs[13] = mk(1, 0, 3, 3, 2, 1, 3, 0);
    vecs[14] = mk(1, 0, 4, 9, 2, 0, 3, 0);
    vecs[15] = mk(1, 0, 0, 9, 2, 1, 4, 0);
    vecs[16] = mk(1, 0, 1, 9, 2, 1, 5, 0);
    vecs[17] = mk(1, 0, 2, 9, 3, 1, 6, 1);
    vecs[18] = mk(1, 0, 3, 9, 3, 0, 6, 1);
    vecs[19] = mk(0, 0, 0, 9, 3, 0, 6, 1);
    vecs[20] = mk(1, 1, 0, 9, 0, 0, 0, 0);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    vecs[22] = mk(1, 0, 0, 0, 1, 0, 0, 0);

    rst = 1; en = 1; clr = 1; g = 8'h3; d = 8'h9;
    s_rst = 1; s_en = 0; s_clr = 0; s_g = 0; s_d = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset state", 16'(st), 16'd0);
    chk("reset count", cnt, 16'd0);
    chk("reset mismatch", 16'(mm), 16'd0);
    chk("reset fail", 16'(fail), 16'd0);
    chk("reset locked", 16'(locked), 16'd0);
    chk("reset seq", 16'(seq), 16'd0);
    @(negedge clk);
    rst = 0; en = 0; clr = 0; g = 0; d = 0;
    s_rst = 0;

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].en, vecs[i].clr, vecs[i].g, vecs[i].d);
      chk($sformatf("v%0d state", i), 16'(st), 16'(vecs[i].st));
      chk($sformatf("v%0d mismatch", i), 16'(mm), 16'(vecs[i].mm));
      chk($sformatf("v%0d count", i), cnt, vecs[i].cnt);
      chk($sformatf("v%0d fail", i), 16'(fail), 16'(vecs[i].fail));
      chk($sformatf("v%0d locked", i), 16'(locked), 16'(vecs[i].st == 2'd2));
      chk($sformatf("v%0d seq", i), 16'(seq), 16'd0);
    end

    // A clear coinciding with a threshold-reaching mismatch must win.
    lock_in("clrwin");
    step(1, 0, 2, 9);
    step(1, 0, 2, 9);
    step(1, 0, 2, 9);
    chk("clrwin pre count", cnt, 16'd2);
    step(1, 1, 2, 2);
    chk("clrwin state", 16'(st), 16'd0);
    chk("clrwin count", cnt, 16'd0);
    chk("clrwin mismatch", 16'(mm), 16'd0);
    chk("clrwin fail", 16'(fail), 16'd0);

    // Enable drop keeps the total but resets the consecutive run.
    lock_in("endrop");
    step(1, 0, 2, 9);
    step(1, 0, 2, 2);
    chk("endrop pulse", 16'(mm), 16'd1);
    step(0, 0, 2, 2);
    chk("endrop state", 16'(st), 16'd0);
    chk("endrop count kept", cnt, 16'd1);
    chk("endrop mismatch", 16'(mm), 16'd0);
    lock_in("relock");
    step(1, 0, 2, 9);
    step(1, 0, 2, 9);
    step(1, 0, 2, 2);
    step(1, 0, 2, 2);
    chk("consec cleared state", 16'(st), 16'd2);
    chk("consec cleared fail", 16'(fail), 16'd0);
    chk("consec cleared count", cnt, 16'd3);

    // Golden continuity: 4 -> 0 wraps legally, 1 -> 3 is a jump.
    step(1, 0, 3, 3);
    step(1, 0, 4, 4);
    step(1, 0, 0, 0);
    step(1, 0, 1, 1);
    step(1, 0, 3, 3);
    chk("wrap state", 16'(st), 16'd2);
    chk("wrap seq", 16'(seq), 16'd0);
    step(1, 0, 3, 3);
    chk("jump seq", 16'(seq), 16'(exp_seq_err));
    chk("jump fail", 16'(fail), 16'(exp_seq_err));
    chk("jump state", 16'(st), exp_seq_err ? 16'd3 : 16'd2);
    chk("jump count", cnt, 16'd3);

    // Reset overrides enable and mismatching data.
    @(negedge clk);
    rst = 1; en = 1; clr = 0; g = 3; d = 9;
    @(posedge clk);
    #1;
    chk("midrst state", 16'(st), 16'd0);
    chk("midrst count", cnt, 16'd0);
    chk("midrst mismatch", 16'(mm), 16'd0);
    chk("midrst fail", 16'(fail), 16'd0);
    chk("midrst seq", 16'(seq), 16'd0);
    chk("midrst locked", 16'(locked), 16'd0);
    @(negedge clk);
    rst = 0; en = 1; g = 0; d = 0;
    @(posedge clk);
    #1;
    chk("postrst sync", 16'(st), 16'd1);

    // Saturation on the ERR_THRESHOLD=15 instance: 14 mismatches then 1 match, repeated.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      s_en = 1; s_g = (i < 3) ? 8'd0 : 8'd1; s_d = s_g;
    end
    @(posedge clk);
    #1;
    chk("sat lock", 16'(s_st), 16'd2);
    for (int i = 0; i < 70500; i++) begin
      @(negedge clk);
      s_g = 8'd1;
      s_d = (i % 15 == 14) ? 8'd1 : 8'h55;
    end
    @(negedge clk);
    s_d = 8'h55;
    repeat (2) @(posedge clk);
    #1;
    chk("sat count", s_cnt, 16'hFFFF);
    chk("sat state", 16'(s_st), 16'd2);
    chk("sat fail", 16'(s_fail), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
